// File: rtl/serial_subtractor_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor_pkg
//  Description : Shared constants and state encoding for the serial subtractor.
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 16;

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] RUN  = 2'b01;
    localparam logic [1:0] DONE = 2'b10;

endpackage
`default_nettype wire

// File: rtl/serial_subtractor_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor_if
//  Description : Operand/result bundle between a requester and the subtractor.
//  Revision    : 1.0 - initial release
// ============================================================================
interface serial_subtractor_if #(
    parameter int WIDTH = serial_subtractor_pkg::DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             ovf;
    logic             zero;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow, ovf, zero
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow, ovf, zero
    );
endinterface
`default_nettype wire

// File: rtl/serial_subtractor_full_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : full_subtractor
//  Description : One-bit subtract cell with borrow in/out.
//  Revision    : 1.0 - initial release
// ============================================================================
module full_subtractor (
    input  wire logic x,
    input  wire logic y,
    input  wire logic bin,
    output logic      d,
    output logic      bout
);
    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);
endmodule
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor
//  Description : Bit-serial a-b, LSB first, one bit per clock, with flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    serial_subtractor_if.slave bus
);
    localparam int             CW     = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  C_LAST = CW'(WIDTH - 1);

    logic [1:0]       r_rst_sync;
    logic             w_rst_n;

    logic [1:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_res;
    logic             r_bin;
    logic             r_a_msb;
    logic             r_b_msb;

    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic             r_ovf;
    logic             r_zero;

    logic             w_d;
    logic             w_bout;
    logic [WIDTH-1:0] w_res_next;

    // Assert asynchronously, release only after two clean clock edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    full_subtractor u_full_subtractor (
        .x    (r_a_sh[0]),
        .y    (r_b_sh[0]),
        .bin  (r_bin),
        .d    (w_d),
        .bout (w_bout)
    );

    assign w_res_next = {w_d, r_res[WIDTH-1:1]};

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_res    <= '0;
            r_bin    <= 1'b0;
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        r_a_sh  <= bus.a;
                        r_b_sh  <= bus.b;
                        r_a_msb <= bus.a[WIDTH-1];
                        r_b_msb <= bus.b[WIDTH-1];
                        r_res   <= '0;
                        r_bin   <= 1'b0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_a_sh <= r_a_sh >> 1;
                    r_b_sh <= r_b_sh >> 1;
                    r_res  <= w_res_next;
                    r_bin  <= w_bout;
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == C_LAST) begin
                        // Result registers change only here, so they hold between operations.
                        r_state  <= DONE;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_diff   <= w_res_next;
                        r_borrow <= w_bout;
                        r_ovf    <= (r_a_msb != r_b_msb) && (w_res_next[WIDTH-1] != r_a_msb);
                        r_zero   <= (w_res_next == '0);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.diff   = r_diff;
    assign bus.borrow = r_borrow;
    assign bus.ovf    = r_ovf;
    assign bus.zero   = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_subtractor
//  Description : Directed and random checks of serial_subtractor at WIDTH=16.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    int   done_cnt;
    int   n_exp;

    serial_subtractor_if #(.WIDTH(16)) bus ();

    serial_subtractor #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.done === 1'b1) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge; the following rising edge accepts.
    task automatic pulse_start(input logic [15:0] a, input logic [15:0] b);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = ~a;
        bus.b     = ~b;
        n_exp++;
    endtask

    task automatic wait_done(input int lat0, output int lat);
        lat = lat0;
        while (bus.done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] ed, input logic eb, input logic eo, input logic ez);
        int lat;
        pulse_start(a, b);
        check({tag, "_busy_run"}, bus.busy, 1);
        wait_done(1, lat);
        check({tag, "_latency"}, lat, 17);
        check({tag, "_busy_done"}, bus.busy, 0);
        check({tag, "_diff"}, bus.diff, ed);
        check({tag, "_borrow"}, bus.borrow, eb);
        check({tag, "_ovf"}, bus.ovf, eo);
        check({tag, "_zero"}, bus.zero, ez);
        @(negedge clk);
        check({tag, "_done_pulse"}, bus.done, 0);
    endtask

    initial begin
        int          lat;
        int          dc;
        logic [15:0] ra;
        logic [15:0] rb;
        logic [16:0] full;
        int          sd;
        logic        eo;

        errors    = 0;
        checks    = 0;
        done_cnt  = 0;
        n_exp     = 0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        rst_n     = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_diff", bus.diff, 0);
        check("rst_borrow", bus.borrow, 0);
        check("rst_ovf", bus.ovf, 0);
        check("rst_zero", bus.zero, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("zero_after_rst", bus.zero, 0);

        run_op("s5m3", 16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0, 1'b0);
        run_op("s3m5", 16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0, 1'b0);
        run_op("ovf",  16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b0);
        run_op("eq",   16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b1);

        // Start during RUN must be ignored.
        pulse_start(16'h1111, 16'h0101);
        repeat (4) @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 16'hFFFF;
        bus.b     = 16'h0000;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(6, lat);
        check("midrun_latency", lat, 17);
        check("midrun_diff", bus.diff, 16'h1010);
        check("midrun_borrow", bus.borrow, 0);
        check("midrun_ovf", bus.ovf, 0);

        // Start in the DONE cycle: back to back.
        pulse_start(16'h0010, 16'h0020);
        check("b2b_busy", bus.busy, 1);
        check("b2b_done_low", bus.done, 0);
        wait_done(1, lat);
        check("b2b_latency", lat, 17);
        check("b2b_diff", bus.diff, 16'hFFF0);
        check("b2b_borrow", bus.borrow, 1);
        check("b2b_ovf", bus.ovf, 0);
        check("b2b_zero", bus.zero, 0);
        @(negedge clk);

        // Reset at RUN cycle 7 aborts with no done pulse.
        pulse_start(16'h00FF, 16'h0001);
        repeat (6) @(negedge clk);
        dc    = done_cnt;
        rst_n = 1'b0;
        #1;
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_diff", bus.diff, 0);
        check("abort_borrow", bus.borrow, 0);
        check("abort_ovf", bus.ovf, 0);
        check("abort_zero", bus.zero, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n_exp--;
        repeat (4) @(negedge clk);
        check("abort_no_done", done_cnt, dc);
        check("abort_idle_busy", bus.busy, 0);
        run_op("after_rst", 16'h00FF, 16'h0001, 16'h00FE, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 2000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (i % 50 == 0) rb = ra;
            full = {1'b0, ra} - {1'b0, rb};
            sd   = int'($signed(ra)) - int'($signed(rb));
            eo   = (sd > 32767) || (sd < -32768);
            run_op("rand", ra, rb, full[15:0], full[16], eo, full[15:0] == 16'h0000);
        end

        repeat (2) @(negedge clk);
        check("done_count", done_cnt, n_exp);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
